// File: rtl/cmd_ctrl_pkg.sv
// Shared constants for the command controller: header field layout, opcode map,
// FSM encoding and the header classification helper.
package cmd_ctrl_pkg;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int ARGC_MSB = 27;
  localparam int ARGC_LSB = 26;
  localparam int IMM_MSB  = 25;
  localparam int IMM_LSB  = 0;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_CLR_ERR = 4'hF;
  localparam logic [3:0] OP_ENG_MIN = 4'h1;
  localparam logic [3:0] OP_ENG_MAX = 4'h7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARG   = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    HDR_NOP = 2'd0,
    HDR_CLR = 2'd1,
    HDR_ENG = 2'd2,
    HDR_BAD = 2'd3
  } hdr_kind_t;

  // NOP and CLR_ERR ignore argc; engine opcodes need argc 0-2.
  function automatic hdr_kind_t classify_hdr(input logic [3:0] op, input logic [1:0] argc);
    hdr_kind_t kind;
    if (op == OP_NOP)
      kind = HDR_NOP;
    else if (op == OP_CLR_ERR)
      kind = HDR_CLR;
    else if (op >= OP_ENG_MIN && op <= OP_ENG_MAX && argc != 2'd3)
      kind = HDR_ENG;
    else
      kind = HDR_BAD;
    return kind;
  endfunction

endpackage

// File: rtl/cmd_ctrl.sv
// Command controller: pops header plus up to two operand words from the command
// buffer, issues a one-cycle engine start and waits for engine completion.
module cmd_ctrl #(
  parameter int WDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_buff_ctrl_out_vld,
  input  logic [WDATA_WIDTH-1:0] cmd_buff_ctrl_out_data,
  output logic                   ctrl_cmd_buff_rdy,
  output logic                   ctrl_eng_start,
  output logic [2:0]             ctrl_eng_op,
  output logic [25:0]            ctrl_eng_imm,
  output logic [WDATA_WIDTH-1:0] ctrl_eng_arg0,
  output logic [WDATA_WIDTH-1:0] ctrl_eng_arg1,
  input  logic                   eng_ctrl_done,
  output logic                   ctrl_busy,
  output logic                   ctrl_err,
  output logic [15:0]            ctrl_cmd_cnt
);
  import cmd_ctrl_pkg::*;

  state_t     state;
  logic [1:0] argc_q;
  logic       arg_idx;
  logic       xfer;
  logic [3:0] hdr_op;
  logic [1:0] hdr_argc;
  hdr_kind_t  hdr_kind;

  assign ctrl_cmd_buff_rdy = (state == IDLE) || (state == ARG);
  assign ctrl_busy         = (state != IDLE);
  assign xfer              = cmd_buff_ctrl_out_vld & ctrl_cmd_buff_rdy;
  assign hdr_op            = cmd_buff_ctrl_out_data[OP_MSB:OP_LSB];
  assign hdr_argc          = cmd_buff_ctrl_out_data[ARGC_MSB:ARGC_LSB];
  assign hdr_kind          = classify_hdr(hdr_op, hdr_argc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      argc_q         <= 2'd0;
      arg_idx        <= 1'b0;
      ctrl_eng_start <= 1'b0;
      ctrl_eng_op    <= 3'd0;
      ctrl_eng_imm   <= 26'd0;
      ctrl_eng_arg0  <= '0;
      ctrl_eng_arg1  <= '0;
      ctrl_err       <= 1'b0;
      ctrl_cmd_cnt   <= 16'd0;
    end else begin
      ctrl_eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            case (hdr_kind)
              HDR_NOP: ctrl_cmd_cnt <= ctrl_cmd_cnt + 16'd1;
              HDR_CLR: ctrl_err     <= 1'b0;
              HDR_BAD: ctrl_err     <= 1'b1;
              HDR_ENG: begin
                // Operands clear here so an argc<2 command presents zeros in the unused slots.
                ctrl_eng_op   <= hdr_op[2:0];
                ctrl_eng_imm  <= cmd_buff_ctrl_out_data[IMM_MSB:IMM_LSB];
                ctrl_eng_arg0 <= '0;
                ctrl_eng_arg1 <= '0;
                argc_q        <= hdr_argc;
                arg_idx       <= 1'b0;
                if (hdr_argc == 2'd0) begin
                  state          <= ISSUE;
                  ctrl_eng_start <= 1'b1;
                end else begin
                  state <= ARG;
                end
              end
              default: ctrl_err <= 1'b1;
            endcase
          end
        end
        ARG: begin
          if (xfer) begin
            if (!arg_idx)
              ctrl_eng_arg0 <= cmd_buff_ctrl_out_data;
            else
              ctrl_eng_arg1 <= cmd_buff_ctrl_out_data;
            arg_idx <= 1'b1;
            if ({1'b0, arg_idx} + 2'd1 == argc_q) begin
              state          <= ISSUE;
              ctrl_eng_start <= 1'b1;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (eng_ctrl_done) begin
            state        <= IDLE;
            ctrl_cmd_cnt <= ctrl_cmd_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
